// File: rtl/mem_burst_pkg.sv
// Shared types for the burst splitter: FSM states, the latched burst command
// and the beat size that sets the address stride.
package mem_burst_pkg;

  localparam int unsigned CmdAddrWidth = 32;
  localparam int unsigned CmdLenWidth  = 8;
  localparam int unsigned CmdDataWidth = 32;
  localparam int unsigned BytesPerBeat = CmdDataWidth / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } burst_state_e;

  typedef struct packed {
    logic [CmdAddrWidth-1:0] addr;
    logic [CmdLenWidth-1:0]  len;
    logic                    we;
  } burst_cmd_t;

endpackage

// File: rtl/mem_burst_splitter_credit.sv
// Saturating up/down counter of requests issued but not yet answered.
module burst_credit_cnt #(
  parameter int unsigned CntWidth = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic                dec_i,
  input  logic [CntWidth-1:0] max_i,
  output logic                has_credit_o
);

  logic [CntWidth-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      count_q <= '0;
    end else if (inc_i && !dec_i && (count_q < max_i)) begin
      count_q <= count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign has_credit_o = (count_q < max_i);

  // A response with nothing outstanding means the downstream protocol broke.
  assert property (@(posedge clk_i) disable iff (!rst_ni) dec_i |-> (count_q != '0));

endmodule

// File: rtl/mem_burst_splitter.sv
// Splits one burst command into single-word memory requests and returns the
// in-order responses tagged with last, with a credit bound on requests in flight.
module mem_burst_splitter
  import mem_burst_pkg::*;
#(
  parameter int unsigned AddrWidth      = CmdAddrWidth,
  parameter int unsigned DataWidth      = CmdDataWidth,
  parameter int unsigned LenWidth       = CmdLenWidth,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   burst_addr_i,
  input  logic [LenWidth-1:0]    burst_len_i,
  input  logic                   burst_we_i,
  input  logic                   burst_valid_i,
  output logic                   burst_ready_o,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  input  logic                   mem_resp_valid_i,
  output logic                   mem_resp_ready_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   rlast_o,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned CntWidth    = LenWidth + 1;
  localparam int unsigned CreditWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeatShift   = $clog2(BytesPerBeat);

  burst_state_e        state_q;
  burst_cmd_t          cmd_q;
  logic [CntWidth-1:0] beat_q;
  logic [CntWidth-1:0] resp_q;
  logic                done_q;

  logic in_issue;
  logic in_resp;
  logic accept;
  logic has_credit;
  logic can_issue;
  logic req_hs;
  logic resp_hs;
  logic last_req;
  logic last_resp_hs;

  // Gating with rst_ni forces the idle-facing handshake outputs during reset.
  assign in_issue = rst_ni && (state_q == ISSUE);
  assign in_resp  = rst_ni && ((state_q == ISSUE) || (state_q == DRAIN));
  assign accept   = rst_ni && (state_q == IDLE) && burst_valid_i;

  assign resp_hs      = in_resp && mem_resp_valid_i && rready_i;
  assign can_issue    = has_credit || resp_hs;
  assign req_hs       = mem_req_valid_o && mem_req_ready_i;
  assign last_req     = (beat_q == CntWidth'(cmd_q.len));
  assign last_resp_hs = resp_hs && rlast_o;

  always_comb begin
    burst_ready_o    = !(rst_ni && (state_q != IDLE));
    busy_o           = rst_ni && (state_q != IDLE);
    mem_req_valid_o  = in_issue && can_issue && (cmd_q.we ? wvalid_i : 1'b1);
    wready_o         = in_issue && cmd_q.we && can_issue && mem_req_ready_i;
    mem_addr_o       = AddrWidth'(cmd_q.addr) + (AddrWidth'(beat_q) << BeatShift);
    mem_we_o         = cmd_q.we;
    mem_wdata_o      = wdata_i;
    mem_be_o         = '1;
    rvalid_o         = in_resp && mem_resp_valid_i;
    mem_resp_ready_o = in_resp && rready_i;
    rdata_o          = mem_rdata_i;
    rlast_o          = (resp_q == CntWidth'(cmd_q.len));
    done_o           = done_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      beat_q  <= '0;
      resp_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (burst_valid_i) begin
            cmd_q   <= '{addr: CmdAddrWidth'(burst_addr_i),
                         len:  CmdLenWidth'(burst_len_i),
                         we:   burst_we_i};
            beat_q  <= '0;
            resp_q  <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (req_hs) begin
            beat_q <= beat_q + 1'b1;
            if (last_req) begin
              state_q <= last_resp_hs ? IDLE : DRAIN;
            end
          end
          if (resp_hs) begin
            resp_q <= resp_q + 1'b1;
          end
          if (last_resp_hs) begin
            done_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (resp_hs) begin
            resp_q <= resp_q + 1'b1;
          end
          if (last_resp_hs) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  burst_credit_cnt #(
    .CntWidth (CreditWidth)
  ) u_credit (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (accept),
    .inc_i        (req_hs),
    .dec_i        (resp_hs),
    .max_i        (CreditWidth'(MaxOutstanding)),
    .has_credit_o (has_credit)
  );

endmodule

// File: tb/tb_mem_burst_splitter.sv
// Directed bench for mem_burst_splitter: a counts-level burst model checked every
// cycle, a latency-configurable responder, and literal per-scenario expectations.
module tb_mem_burst_splitter;

  localparam int MAXO = 4;

  logic        clk;
  logic        rst_ni;
  logic [31:0] burst_addr_i;
  logic [7:0]  burst_len_i;
  logic        burst_we_i;
  logic        burst_valid_i;
  logic        burst_ready_o;
  logic [31:0] wdata_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_rdata_i;
  logic        mem_resp_valid_i;
  logic        mem_resp_ready_o;
  logic [31:0] rdata_o;
  logic        rlast_o;
  logic        rvalid_o;
  logic        rready_i;
  logic        busy_o;
  logic        done_o;

  mem_burst_splitter #(
    .AddrWidth      (32),
    .DataWidth      (32),
    .LenWidth       (8),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .burst_addr_i     (burst_addr_i),
    .burst_len_i      (burst_len_i),
    .burst_we_i       (burst_we_i),
    .burst_valid_i    (burst_valid_i),
    .burst_ready_o    (burst_ready_o),
    .wdata_i          (wdata_i),
    .wvalid_i         (wvalid_i),
    .wready_o         (wready_o),
    .mem_addr_o       (mem_addr_o),
    .mem_we_o         (mem_we_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_be_o         (mem_be_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_rdata_i      (mem_rdata_i),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .rdata_o          (rdata_o),
    .rlast_o          (rlast_o),
    .rvalid_o         (rvalid_o),
    .rready_i         (rready_i),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents seen by the responder: word 0x100 holds 0xA0, then +1 per word.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'hA0 + ((addr - 32'h100) >> 2);
  endfunction

  typedef struct {
    logic [31:0] data;
    int          rdy;
  } rsp_t;

  // Environment knobs set by the stimulus
  int  lat = 1;
  bit  rready_rand = 0;
  int  w_gap_cfg = 0;
  int  w_gap_left = 0;
  logic [31:0] wq[$];
  rsp_t rq[$];

  // Burst model: counts only
  bit          m_busy = 0;
  logic [31:0] m_base = '0;
  int          m_len = 0;
  bit          m_we = 0;
  int          m_issued = 0;
  int          m_resp = 0;
  int          m_out = 0;
  bit          m_done_pending = 0;
  logic [31:0] m_dq[$];
  int          accept_cnt = 0;

  // DUT-side captures for literal expectations
  logic [31:0] cap_addr[$];
  logic [31:0] cap_wdata[$];
  logic [31:0] cap_rdata[$];
  logic        cap_rlast[$];
  int          cap_req_cyc[$];
  int          cap_done = 0;
  int          cap_both = 0;

  always begin
    bit busy_e, issuing, e_resp_hs, e_can, e_req_valid, e_wready, e_req_hs;
    logic [31:0] e_addr;
    @(negedge clk);
    #1;
    if (rq.size() > 0 && rq[0].rdy <= cyc) begin
      mem_resp_valid_i = 1'b1;
      mem_rdata_i      = rq[0].data;
    end else begin
      mem_resp_valid_i = 1'b0;
      mem_rdata_i      = 32'hDEADBEEF;
    end
    rready_i = rready_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    if (wq.size() > 0 && w_gap_left == 0) begin
      wvalid_i = 1'b1;
      wdata_i  = wq[0];
    end else begin
      wvalid_i = 1'b0;
      wdata_i  = 32'h0BAD_0BAD;
    end
    #1;
    busy_e      = rst_ni && m_busy;
    issuing     = busy_e && (m_issued <= m_len);
    e_resp_hs   = busy_e && mem_resp_valid_i && rready_i;
    e_can       = (m_out < MAXO) || e_resp_hs;
    e_req_valid = issuing && e_can && (m_we ? wvalid_i : 1'b1);
    e_wready    = issuing && m_we && e_can && mem_req_ready_i;
    e_req_hs    = e_req_valid && mem_req_ready_i;
    e_addr      = m_base + (32'(m_issued) << 2);

    check_b("burst_ready", burst_ready_o, !busy_e);
    check_b("busy", busy_o, busy_e);
    check_b("req_valid", mem_req_valid_o, e_req_valid);
    check_b("wready", wready_o, e_wready);
    check_b("rvalid", rvalid_o, busy_e && mem_resp_valid_i);
    check_b("resp_ready", mem_resp_ready_o, busy_e && rready_i);
    check_b("done", done_o, m_done_pending);
    if (e_req_valid) begin
      check_w("req_addr", mem_addr_o, e_addr);
      check_b("req_we", mem_we_o, m_we);
      check_w("req_be", 32'(mem_be_o), 32'hF);
      if (m_we) check_w("req_wdata", mem_wdata_o, wdata_i);
    end
    if (e_resp_hs) begin
      check_b("rlast", rlast_o, m_resp == m_len);
      if (!m_we && m_dq.size() > 0) check_w("rdata", rdata_o, m_dq[0]);
    end

    if (mem_req_valid_o && mem_req_ready_i) begin
      cap_addr.push_back(mem_addr_o);
      cap_wdata.push_back(mem_wdata_o);
      cap_req_cyc.push_back(cyc);
    end
    if (rvalid_o && rready_i) begin
      cap_rdata.push_back(rdata_o);
      cap_rlast.push_back(rlast_o);
    end
    if (done_o) cap_done++;
    if (mem_req_valid_o && mem_req_ready_i && rvalid_o && rready_i) cap_both++;

    if (!rst_ni) begin
      m_busy = 0; m_out = 0; m_issued = 0; m_resp = 0; m_done_pending = 0;
      rq.delete();
      m_dq.delete();
    end else begin
      m_done_pending = 0;
      if (!m_busy) begin
        if (burst_valid_i) begin
          m_busy = 1; m_base = burst_addr_i; m_len = int'(burst_len_i); m_we = burst_we_i;
          m_issued = 0; m_resp = 0; m_out = 0;
          accept_cnt++;
        end
      end else begin
        if (e_req_hs) begin
          rq.push_back('{data: mem_word(e_addr), rdy: cyc + lat});
          m_dq.push_back(mem_word(e_addr));
          m_issued++;
          m_out++;
        end
        if (e_resp_hs) begin
          void'(rq.pop_front());
          void'(m_dq.pop_front());
          m_resp++;
          m_out--;
          if (m_resp == m_len + 1) begin
            m_busy = 0;
            m_done_pending = 1;
          end
        end
      end
      if (wvalid_i && e_wready) begin
        void'(wq.pop_front());
        w_gap_left = w_gap_cfg;
      end else if (!wvalid_i && wq.size() > 0 && w_gap_left > 0 && m_busy) begin
        w_gap_left--;
      end
    end
    cyc++;
  end

  task automatic clear_caps();
    cap_addr.delete(); cap_wdata.delete(); cap_rdata.delete();
    cap_rlast.delete(); cap_req_cyc.delete();
    cap_done = 0;
    cap_both = 0;
  endtask

  task automatic start_burst(input logic [31:0] a, input logic [7:0] l, input logic w);
    int n0;
    int g;
    n0 = accept_cnt;
    g = 0;
    @(negedge clk);
    burst_addr_i  = a;
    burst_len_i   = l;
    burst_we_i    = w;
    burst_valid_i = 1'b1;
    while (accept_cnt == n0 && g < 50) begin
      @(posedge clk);
      g++;
    end
    check_b("burst_accepted", accept_cnt != n0, 1'b1);
    @(negedge clk);
    burst_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (m_busy && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check_b("burst_finished", m_busy, 1'b0);
    #3;
  endtask

  task automatic run_burst(input logic [31:0] a, input logic [7:0] l, input logic w);
    start_burst(a, l, w);
    wait_done();
  endtask

  task automatic check_read_seq(input string tag, input logic [31:0] a0, input int n);
    check_w({tag, "_nreq"}, 32'(cap_addr.size()), 32'(n));
    check_w({tag, "_nresp"}, 32'(cap_rdata.size()), 32'(n));
    if (cap_rdata.size() == n && cap_addr.size() == n) begin
      for (int i = 0; i < n; i++) begin
        check_w({tag, "_addr"}, cap_addr[i], a0 + 32'(i * 4));
        check_w({tag, "_data"}, cap_rdata[i], mem_word(a0) + 32'(i));
        check_b({tag, "_last"}, cap_rlast[i], i == n - 1);
      end
    end
    check_w({tag, "_done"}, 32'(cap_done), 32'd1);
    check_b({tag, "_idle"}, busy_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    burst_addr_i = '0; burst_len_i = '0; burst_we_i = 1'b0; burst_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    wdata_i = '0; wvalid_i = 1'b0; rready_i = 1'b1;
    mem_resp_valid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    #3;
    check_b("reset_busy", busy_o, 1'b0);
    check_b("reset_burst_ready", burst_ready_o, 1'b1);
    check_b("reset_req_valid", mem_req_valid_o, 1'b0);
    check_b("reset_done", done_o, 1'b0);

    // Read burst, 1-cycle responder: 0x100..0x10C -> 0xA0..0xA3
    clear_caps();
    lat = 1;
    run_burst(32'h100, 8'd3, 1'b0);
    check_read_seq("rd4", 32'h100, 4);
    check_w("rd4_first_data", cap_rdata.size() > 0 ? cap_rdata[0] : 32'hX, 32'hA0);

    // Write burst with 2-cycle wvalid gaps before each beat
    clear_caps();
    wq = '{32'h11, 32'h22};
    w_gap_cfg = 2;
    w_gap_left = 2;
    run_burst(32'h40, 8'd1, 1'b1);
    check_w("wr_nreq", 32'(cap_addr.size()), 32'd2);
    check_w("wr_nresp", 32'(cap_rlast.size()), 32'd2);
    if (cap_addr.size() == 2 && cap_rlast.size() == 2) begin
      check_w("wr_addr0", cap_addr[0], 32'h40);
      check_w("wr_addr1", cap_addr[1], 32'h44);
      check_w("wr_data0", cap_wdata[0], 32'h11);
      check_w("wr_data1", cap_wdata[1], 32'h22);
      check_w("wr_req_gap", 32'(cap_req_cyc[1] - cap_req_cyc[0]), 32'd3);
      check_b("wr_last0", cap_rlast[0], 1'b0);
      check_b("wr_last1", cap_rlast[1], 1'b1);
    end
    check_w("wr_done", 32'(cap_done), 32'd1);
    w_gap_cfg = 0;
    w_gap_left = 0;

    // Credit limit: 10-cycle responder, 8 beats
    clear_caps();
    lat = 10;
    run_burst(32'h100, 8'd7, 1'b0);
    check_read_seq("credit", 32'h100, 8);
    if (cap_req_cyc.size() == 8) begin
      check_w("credit_first4", 32'(cap_req_cyc[3] - cap_req_cyc[0]), 32'd3);
      check_w("credit_stall", 32'(cap_req_cyc[4] - cap_req_cyc[0]), 32'd10);
    end
    check_w("credit_same_cycle", 32'(cap_both), 32'd4);

    // Random response backpressure over 16 beats
    clear_caps();
    lat = 1;
    rready_rand = 1;
    run_burst(32'h200, 8'd15, 1'b0);
    rready_rand = 0;
    check_read_seq("bp", 32'h200, 16);
    check_w("bp_first_data", cap_rdata.size() > 0 ? cap_rdata[0] : 32'hX, 32'hE0);

    // Single-beat burst
    clear_caps();
    run_burst(32'h104, 8'd0, 1'b0);
    check_read_seq("len0", 32'h104, 1);
    check_w("len0_data", cap_rdata.size() > 0 ? cap_rdata[0] : 32'hX, 32'hA1);

    // Address wrap
    clear_caps();
    run_burst(32'hFFFF_FFFC, 8'd1, 1'b0);
    check_w("wrap_nreq", 32'(cap_addr.size()), 32'd2);
    if (cap_addr.size() == 2) begin
      check_w("wrap_addr0", cap_addr[0], 32'hFFFF_FFFC);
      check_w("wrap_addr1", cap_addr[1], 32'h0000_0000);
    end

    // Reset after two of six beats, then a clean burst
    clear_caps();
    start_burst(32'h300, 8'd5, 1'b0);
    for (int g = 0; g < 50 && cap_addr.size() < 2; g++) @(negedge clk);
    check_b("rst_two_beats", cap_addr.size() >= 2, 1'b1);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    #3;
    check_b("rst_mid_busy", busy_o, 1'b0);
    check_b("rst_mid_burst_ready", burst_ready_o, 1'b1);
    check_b("rst_mid_req_valid", mem_req_valid_o, 1'b0);
    clear_caps();
    run_burst(32'h100, 8'd3, 1'b0);
    check_read_seq("post_rst", 32'h100, 4);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_burst_splitter.md
Name: mem_burst_splitter

Overview:
Upstream neighbour of the stream-to-memory adapter. It accepts one burst command at a time, with a base address, beat count and direction. It issues one single-word memory request per beat on a valid/ready stream, which feeds the adapter's request side. It also consumes the adapter's in-order response stream and returns each response tagged with a last flag, plus a one-cycle done pulse per burst. A credit counter bounds the number of requests in flight so the adapter's response buffer cannot overflow.

Parameters:
AddrWidth, 32, byte address width.
DataWidth, 32, data word width; must be a power of two and at least 8.
LenWidth, 8, width of the burst length field; a burst has burst_len_i+1 beats.
MaxOutstanding, 4, maximum number of requests issued but not yet answered; must be at least 1 and should equal the adapter's buffer depth.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
burst_addr_i  in  AddrWidth  burst base byte address; must be word-aligned
burst_len_i  in  LenWidth  number of beats minus 1
burst_we_i  in  1  1 = write burst, 0 = read burst
burst_valid_i  in  1  burst command valid
burst_ready_o  out  1  burst command accepted
wdata_i  in  DataWidth  write data, one word per beat
wvalid_i  in  1  write data valid
wready_o  out  1  write data accepted
mem_addr_o  out  AddrWidth  request address
mem_we_o  out  1  request is a write
mem_wdata_o  out  DataWidth  request write data
mem_be_o  out  DataWidth/8  byte enables; always all ones
mem_req_valid_o  out  1  request valid
mem_req_ready_i  in  1  request accepted downstream
mem_rdata_i  in  DataWidth  response data
mem_resp_valid_i  in  1  response valid
mem_resp_ready_o  out  1  response accepted
rdata_o  out  DataWidth  returned data; don't-care for write bursts
rlast_o  out  1  final response of the burst
rvalid_o  out  1  returned response valid
rready_i  in  1  returned response accepted
busy_o  out  1  state is not IDLE
done_o  out  1  one-cycle pulse when the burst's last response is handshaked

Behaviour:
- Reset state, synchronous to clk_i with rst_ni=0: state IDLE; beat, response and credit counters 0; done_o=0.
- Outputs during reset: burst_ready_o=1, busy_o=0, mem_req_valid_o=0, rvalid_o=0, wready_o=0, mem_resp_ready_o=0.
- A reset asserted mid-burst drops all in-flight context. The environment must also reset the downstream adapter.
- The FSM has three states: IDLE, ISSUE, DRAIN.
- IDLE:
  - burst_ready_o=1.
  - On a burst_valid_i handshake, register addr, len and we; clear the counters; go to ISSUE on the next cycle.
  - No requests are issued and no responses are accepted in IDLE.
- ISSUE:
  - Request condition: can_issue = (outstanding < MaxOutstanding) OR (a response handshake occurs this cycle).
  - mem_req_valid_o = can_issue AND (we ? wvalid_i : 1).
  - wready_o = we AND can_issue AND mem_req_ready_i.
  - mem_addr_o = base + beat*(DataWidth/8), computed modulo 2^AddrWidth (it wraps and no error is raised).
  - mem_wdata_o = wdata_i, combinational pass-through.
  - On each request handshake, beat increments.
  - The handshake with beat==len moves the FSM to DRAIN. If all responses are already complete in that same cycle, it goes straight to IDLE.
- Response path, active in ISSUE and DRAIN:
  - rvalid_o = mem_resp_valid_i.
  - mem_resp_ready_o = rready_i.
  - rdata_o = mem_rdata_i. This path is combinational, adding zero latency.
  - rlast_o = (resp_cnt == len).
  - On each handshake, resp_cnt increments.
- DRAIN: the handshake with rlast_o=1 asserts done_o (registered, high for one cycle after the handshake cycle) and returns the FSM to IDLE.
- Credit counter: outstanding += request handshake; outstanding -= response handshake. When both occur in one cycle, the count is unchanged.
- Request latency: the first request is presented on the cycle after the burst is accepted. With no backpressure, one request issues per cycle.
- len=0 is a single-beat burst. len=2^LenWidth-1 gives 2^LenWidth beats, so the counters must be LenWidth+1 bits wide.
- A response arriving with no request outstanding is a protocol violation. The block checks it with a simulation-only assertion and defines no further behaviour for it.

Decomposition:
- A shared package mem_burst_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN);
  - a burst command struct (addr, len, we);
  - a localparam for bytes per beat.
- One natural sub-module, burst_credit_cnt, implements the saturating up/down outstanding counter. It takes inc, dec and max, and outputs has_credit.
- Everything else stays flat.

Test Plan:
- Read burst addr=0x100, len=3, with mem_req_ready_i=1 and a responder of 1-cycle latency returning data 0xA0..0xA3. Expect requests at 0x100, 0x104, 0x108, 0x10C; rdata 0xA0..0xA3; rlast_o only on 0xA3; done_o one pulse; busy_o low afterwards.
- Write burst addr=0x40, len=1, with wdata 0x11 then 0x22 and wvalid_i held low for 2 cycles before each beat. Expect mem_req_valid_o to follow wvalid_i, mem_we_o=1, mem_be_o=0xF, and two responses with the second carrying rlast.
- Credit limit: MaxOutstanding=4, len=7, responder holds responses for 10 cycles. Expect exactly 4 requests, then mem_req_valid_o=0. After each response one new request issues, including a request and response in the same cycle.
- Backpressure: toggle rready_i randomly during a len=15 read. Expect no lost or duplicated responses, ordering preserved, and done_o exactly once.
- Boundaries: a len=0 burst returns in IDLE one cycle after its single response. Base 0xFFFFFFFC with len=1 issues addresses 0xFFFFFFFC then 0x00000000.
- Reset mid-burst: assert rst_ni=0 for one cycle after 2 of 6 beats. Expect the next cycle to show burst_ready_o=1, busy_o=0 and mem_req_valid_o=0, and a new burst to then run correctly.
